// File: rtl/dphy_tx_lane_seq.sv
// D-PHY transmit lane sequencer: walks one clock lane and LANES data lanes through
// LP11 -> LP01 -> LP00 -> HS-zero -> HS -> trail -> LP11, with every output registered.
module dphy_tx_lane_seq #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned T_LPX       = 4,
  parameter int unsigned T_CLK_PREP  = 3,
  parameter int unsigned T_CLK_ZERO  = 20,
  parameter int unsigned T_CLK_PRE   = 2,
  parameter int unsigned T_HS_PREP   = 4,
  parameter int unsigned T_HS_ZERO   = 10,
  parameter int unsigned T_HS_TRAIL  = 5,
  parameter int unsigned T_CLK_POST  = 8,
  parameter int unsigned T_CLK_TRAIL = 5,
  parameter int unsigned T_HS_EXIT   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hs_req_i,
  input  logic               tx_valid_i,
  input  logic [8*LANES-1:0] tx_data_i,
  output logic               tx_ready_o,
  output logic               busy_o,
  output logic [1:0]         clk_lp_o,
  output logic               clk_hs_oe_o,
  output logic               clk_hs_run_o,
  output logic [1:0]         d_lp_o,
  output logic               d_hs_oe_o,
  output logic [8*LANES-1:0] d_hs_data_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLK_LPX, S_CLK_PREP, S_CLK_ZERO, S_CLK_PRE,
    S_D_LPX, S_D_PREP, S_D_ZERO, S_D_SYNC, S_D_DATA, S_D_TRAIL,
    S_D_EXIT, S_CLK_POST, S_CLK_TRAIL, S_CLK_EXIT
  } state_t;

  // D_EXIT spends one of the T_CLK_POST running-clock cycles, CLK_POST the rest.
  localparam int unsigned POST_DW = (T_CLK_POST > 1) ? T_CLK_POST - 1 : 1;

  function automatic logic [7:0] ld(input int unsigned t);
    return (t == 0) ? 8'd0 : 8'(t - 1);
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [LANES-1:0]   last_bit_q;
  logic               done;

  assign done = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = done ? 8'd0 : cnt_q - 8'd1;
    unique case (state_q)
      S_IDLE:      if (hs_req_i) begin state_d = S_CLK_LPX;   cnt_d = ld(T_LPX);       end
      S_CLK_LPX:   if (done)     begin state_d = S_CLK_PREP;  cnt_d = ld(T_CLK_PREP);  end
      S_CLK_PREP:  if (done)     begin state_d = S_CLK_ZERO;  cnt_d = ld(T_CLK_ZERO);  end
      S_CLK_ZERO:  if (done)     begin state_d = S_CLK_PRE;   cnt_d = ld(T_CLK_PRE);   end
      S_CLK_PRE:   if (done)     begin state_d = S_D_LPX;     cnt_d = ld(T_LPX);       end
      S_D_LPX:     if (done)     begin state_d = S_D_PREP;    cnt_d = ld(T_HS_PREP);   end
      S_D_PREP:    if (done)     begin state_d = S_D_ZERO;    cnt_d = ld(T_HS_ZERO);   end
      S_D_ZERO:    if (done)     begin state_d = S_D_SYNC;    cnt_d = 8'd0;            end
      S_D_SYNC:                  begin state_d = S_D_DATA;    cnt_d = 8'd0;            end
      S_D_DATA:    if (!tx_valid_i) begin state_d = S_D_TRAIL; cnt_d = ld(T_HS_TRAIL); end
      S_D_TRAIL:   if (done)     begin state_d = S_D_EXIT;    cnt_d = 8'd0;            end
      S_D_EXIT:                  begin state_d = S_CLK_POST;  cnt_d = ld(POST_DW);     end
      S_CLK_POST:  if (done)     begin state_d = S_CLK_TRAIL; cnt_d = ld(T_CLK_TRAIL); end
      S_CLK_TRAIL: if (done)     begin state_d = S_CLK_EXIT;  cnt_d = ld(T_HS_EXIT);   end
      S_CLK_EXIT:  if (done)     begin state_d = S_IDLE;      cnt_d = 8'd0;            end
      default:                   begin state_d = S_IDLE;      cnt_d = 8'd0;            end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      last_bit_q   <= '1;
      tx_ready_o   <= 1'b0;
      busy_o       <= 1'b0;
      clk_lp_o     <= 2'b11;
      clk_hs_oe_o  <= 1'b0;
      clk_hs_run_o <= 1'b0;
      d_lp_o       <= 2'b11;
      d_hs_oe_o    <= 1'b0;
      d_hs_data_o  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_ready_o   <= (state_d == S_D_DATA);
      busy_o       <= (state_d != S_IDLE);
      clk_lp_o     <= (state_d inside {S_IDLE, S_CLK_EXIT}) ? 2'b11 :
                      (state_d == S_CLK_LPX) ? 2'b01 : 2'b00;
      clk_hs_oe_o  <= !(state_d inside {S_IDLE, S_CLK_LPX, S_CLK_PREP, S_CLK_EXIT});
      clk_hs_run_o <= (state_d inside {S_CLK_PRE, S_D_LPX, S_D_PREP, S_D_ZERO, S_D_SYNC,
                                       S_D_DATA, S_D_TRAIL, S_D_EXIT, S_CLK_POST});
      d_lp_o       <= (state_d == S_D_LPX) ? 2'b01 :
                      (state_d inside {S_D_PREP, S_D_ZERO, S_D_SYNC, S_D_DATA, S_D_TRAIL})
                      ? 2'b00 : 2'b11;
      d_hs_oe_o    <= (state_d inside {S_D_ZERO, S_D_SYNC, S_D_DATA, S_D_TRAIL});

      // Accepted bytes go out one cycle later; the first D_DATA cycle holds the sync byte.
      if (state_q == S_D_DATA && tx_valid_i) begin
        d_hs_data_o <= tx_data_i;
        for (int k = 0; k < LANES; k++) last_bit_q[k] <= tx_data_i[8*k+7];
      end else if (state_d == S_D_SYNC) begin
        d_hs_data_o <= {LANES{8'hB8}};
        last_bit_q  <= '1;
      end else if (state_d == S_D_TRAIL) begin
        for (int k = 0; k < LANES; k++) d_hs_data_o[8*k +: 8] <= {8{~last_bit_q[k]}};
      end else if (state_d != S_D_DATA) begin
        d_hs_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dphy_tx_lane_seq.sv
// Directed bench for dphy_tx_lane_seq: a 1-lane and a 2-lane instance share control
// stimulus; every expected value below is hand-derived from the default timing.
module tb_dphy_tx_lane_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_req = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data1 = 8'h00;
  logic [15:0] data2 = 16'h0000;

  logic        rdy1, busy1, coe1, run1, doe1;
  logic [1:0]  clp1, dlp1;
  logic [7:0]  hd1;
  logic        rdy2, busy2, coe2, run2, doe2;
  logic [1:0]  clp2, dlp2;
  logic [15:0] hd2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  dphy_tx_lane_seq #(.LANES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .hs_req_i(hs_req), .tx_valid_i(valid), .tx_data_i(data1),
    .tx_ready_o(rdy1), .busy_o(busy1), .clk_lp_o(clp1), .clk_hs_oe_o(coe1),
    .clk_hs_run_o(run1), .d_lp_o(dlp1), .d_hs_oe_o(doe1), .d_hs_data_o(hd1));

  dphy_tx_lane_seq #(.LANES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .hs_req_i(hs_req), .tx_valid_i(valid), .tx_data_i(data2),
    .tx_ready_o(rdy2), .busy_o(busy2), .clk_lp_o(clp2), .clk_hs_oe_o(coe2),
    .clk_hs_run_o(run2), .d_lp_o(dlp2), .d_hs_oe_o(doe2), .d_hs_data_o(hd2));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk_lp"}, {30'd0, clp1}, 32'd3);
    chk({tag, "_d_lp"},   {30'd0, dlp1}, 32'd3);
    chk({tag, "_oe"},     {29'd0, coe1, doe1, run1}, 32'd0);
    chk({tag, "_rdy"},    {30'd0, rdy1, busy1}, 32'd0);
    chk({tag, "_data"},   {24'd0, hd1}, 32'd0);
    chk({tag, "_lp2"},    {28'd0, clp2, dlp2}, 32'hF);
    chk({tag, "_data2"},  {16'd0, hd2}, 32'd0);
  endtask

  // Pulses hs_req at cycle 0 and advances to cycle 49, the first D_DATA cycle.
  task automatic run_to_data();
    cyc = 0;
    hs_req = 1'b1;
    step();
    hs_req = 1'b0;
    repeat (48) step();
    chk("data_entry_rdy", {31'd0, rdy1}, 32'd1);
  endtask

  initial begin
    int run_len;
    int gaps;
    bit active;

    // Reset state
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    // Zero-length burst, request pulsed at cycle 0, a stray request during CLK_EXIT
    cyc = 0;
    hs_req = 1'b1;
    for (int c = 1; c <= 77; c++) begin
      step();
      hs_req = (c == 70);
      chk("t1_clk_lp", {30'd0, clp1},
          (c <= 4) ? 32'd1 : (c <= 67) ? 32'd0 : 32'd3);
      chk("t1_clk_oe", {31'd0, coe1}, (c >= 8 && c <= 67) ? 32'd1 : 32'd0);
      chk("t1_run",    {31'd0, run1}, (c >= 28 && c <= 62) ? 32'd1 : 32'd0);
      chk("t1_d_lp",   {30'd0, dlp1},
          (c >= 30 && c <= 33) ? 32'd1 : (c >= 34 && c <= 54) ? 32'd0 : 32'd3);
      chk("t1_d_oe",   {31'd0, doe1}, (c >= 38 && c <= 54) ? 32'd1 : 32'd0);
      chk("t1_rdy",    {31'd0, rdy1}, (c == 49) ? 32'd1 : 32'd0);
      chk("t1_busy",   {31'd0, busy1}, (c <= 75) ? 32'd1 : 32'd0);
      if (c != 49) begin
        chk("t1_data",  {24'd0, hd1}, (c == 48) ? 32'hB8 : 32'd0);
        chk("t1_data2", {16'd0, hd2}, (c == 48) ? 32'hB8B8 : 32'd0);
      end
      chk("t1_lp2", {28'd0, clp2, dlp2}, {28'd0, clp1, dlp1});
    end
    hs_req = 1'b0;

    // Three-byte burst; lane pair on dut2 ends with 0x80_01
    run_to_data();
    valid = 1'b1; data1 = 8'h11; data2 = 16'h1111;
    step();
    chk("t2_b0", {24'd0, hd1}, 32'h11);
    chk("t2_rdy50", {31'd0, rdy1}, 32'd1);
    data1 = 8'h22; data2 = 16'h2222;
    step();
    chk("t2_b1", {24'd0, hd1}, 32'h22);
    chk("t2_b1_l2", {16'd0, hd2}, 32'h2222);
    chk("t2_rdy51", {31'd0, rdy1}, 32'd1);
    data1 = 8'h83; data2 = 16'h8001;
    step();
    chk("t2_b2", {24'd0, hd1}, 32'h83);
    chk("t2_b2_l2", {16'd0, hd2}, 32'h8001);
    chk("t2_rdy52", {31'd0, rdy1}, 32'd1);
    valid = 1'b0; data1 = 8'hEE; data2 = 16'hEEEE;
    for (int c = 53; c <= 57; c++) begin
      step();
      chk("t2_rdy_low", {31'd0, rdy1}, 32'd0);
      chk("t2_trail",   {24'd0, hd1}, 32'h00);
      chk("t2_trail2",  {16'd0, hd2}, 32'h00FF);
      chk("t2_trail_oe", {31'd0, doe1}, 32'd1);
    end
    step();
    chk("t2_exit_dlp", {30'd0, dlp1}, 32'd3);
    chk("t2_exit_oe",  {31'd0, doe1}, 32'd0);
    chk("t2_exit_run", {31'd0, run1}, 32'd1);
    repeat (20) step();
    chk("t2_busy78", {31'd0, busy1}, 32'd1);
    step();
    chk("t2_busy79", {31'd0, busy1}, 32'd0);

    // Single byte with bit7 clear: inverted trail
    run_to_data();
    valid = 1'b1; data1 = 8'h7F; data2 = 16'h7F7F;
    step();
    chk("t3_b0", {24'd0, hd1}, 32'h7F);
    valid = 1'b0; data1 = 8'h00; data2 = 16'h0000;
    for (int c = 51; c <= 55; c++) begin
      step();
      chk("t3_trail",  {24'd0, hd1}, 32'hFF);
      chk("t3_trail2", {16'd0, hd2}, 32'hFFFF);
    end
    step();
    chk("t3_exit_data", {24'd0, hd1}, 32'h00);
    chk("t3_exit_dlp",  {30'd0, dlp1}, 32'd3);
    repeat (21) step();
    chk("t3_busy77", {31'd0, busy1}, 32'd0);

    // Reset while in D_DATA, then a fresh request
    run_to_data();
    valid = 1'b1; data1 = 8'h55; data2 = 16'h5555;
    step();
    chk("t4_pre_rst", {24'd0, hd1}, 32'h55);
    rst = 1'b1;
    step();
    chk_idle("t4_rst");
    rst = 1'b0; valid = 1'b0;
    cyc = 0;
    hs_req = 1'b1;
    step();
    hs_req = 1'b0;
    chk("t4_lpx",  {30'd0, clp1}, 32'd1);
    chk("t4_busy", {31'd0, busy1}, 32'd1);
    repeat (4) step();
    chk("t4_prep", {30'd0, clp1}, 32'd0);

    // Request held high: LP11 gaps between bursts and LP legality
    hs_req = 1'b1;
    run_len = 0; gaps = 0; active = 1'b0;
    for (int i = 0; i < 240; i++) begin
      step();
      chk("t5_clk_lp10", {31'd0, clp1 == 2'b10}, 32'd0);
      chk("t5_d_lp10",   {31'd0, dlp1 == 2'b10}, 32'd0);
      chk("t5_clk_oe_lp", {31'd0, coe1 && clp1 != 2'b00}, 32'd0);
      chk("t5_d_oe_lp",   {31'd0, doe1 && dlp1 != 2'b00}, 32'd0);
      if (clp1 == 2'b11 && dlp1 == 2'b11) begin
        run_len++;
      end else begin
        if (active && run_len > 0) begin
          chk("t5_exit_gap", run_len, 32'd9);
          gaps++;
        end
        run_len = 0;
        active = 1'b1;
      end
    end
    hs_req = 1'b0;
    chk("t5_gap_count", {31'd0, gaps >= 2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
